// File: rtl/axi_ram_init_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : axi_ram_init_ctrl
// Brief   : AXI4 write-only master that clears or fills external RAM after
//           reset using fixed-length INCR bursts.
//           Optional macro RAM_INIT_PATTERN_EN: write an address-derived word
//           per beat instead of FILL_DATA.
// Revision: 1.0
// ============================================================================
module axi_ram_init_ctrl #(
    parameter int unsigned ID_WIDTH   = 6,
    parameter logic [31:0] MEM_SIZE   = 32'h10000,
    parameter logic [31:0] BASE_ADDR  = 32'h0,
    parameter int unsigned BURST_LEN  = 16,
    parameter logic [63:0] FILL_DATA  = 64'h0,
    parameter bit          AUTO_START = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_start,
    output logic [ID_WIDTH-1:0] o_awid,
    output logic [31:0]         o_awaddr,
    output logic [7:0]          o_awlen,
    output logic [2:0]          o_awsize,
    output logic [1:0]          o_awburst,
    output logic                o_awvalid,
    input  logic                i_awready,
    output logic [63:0]         o_wdata,
    output logic [7:0]          o_wstrb,
    output logic                o_wlast,
    output logic                o_wvalid,
    input  logic                i_wready,
    input  logic [ID_WIDTH-1:0] i_bid,
    input  logic [1:0]          i_bresp,
    input  logic                i_bvalid,
    output logic                o_bready,
    output logic                o_init_done,
    output logic                o_init_error
);

    localparam logic [7:0]  c_LAST_BEAT   = 8'(BURST_LEN - 1);
    localparam logic [31:0] c_BURST_BYTES = 32'(BURST_LEN * 8);
    // 33-bit end address so a region ending exactly at 2^32 compares correctly
    localparam logic [32:0] c_END_ADDR    = {1'b0, BASE_ADDR} + {1'b0, MEM_SIZE};

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_AW   = 3'd1,
        S_W    = 3'd2,
        S_B    = 3'd3,
        S_DONE = 3'd4,
        S_ERR  = 3'd5
    } state_t;

    state_t      r_state;
    logic [7:0]  r_beat;
    logic [32:0] w_next_addr;
    logic        w_last_burst;
    logic        w_unused_bid;

    assign w_next_addr  = {1'b0, o_awaddr} + {1'b0, c_BURST_BYTES};
    assign w_last_burst = (w_next_addr == c_END_ADDR);
    assign w_unused_bid = ^i_bid;

    assign o_awid    = '0;
    assign o_awlen   = c_LAST_BEAT;
    assign o_awsize  = 3'd3;
    assign o_awburst = 2'b01;
    assign o_wstrb   = 8'hFF;

`ifdef RAM_INIT_PATTERN_EN
    logic [31:0] w_beat_addr;
    assign w_beat_addr = o_awaddr + {21'd0, r_beat, 3'd0};
    assign o_wdata     = {~w_beat_addr, w_beat_addr};
`else
    assign o_wdata = FILL_DATA;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_beat       <= 8'd0;
            o_awaddr     <= BASE_ADDR;
            o_awvalid    <= 1'b0;
            o_wvalid     <= 1'b0;
            o_wlast      <= 1'b0;
            o_bready     <= 1'b0;
            o_init_done  <= 1'b0;
            o_init_error <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (AUTO_START || i_start) begin
                        o_awvalid <= 1'b1;
                        r_state   <= S_AW;
                    end
                end
                S_AW: begin
                    if (i_awready) begin
                        o_awvalid <= 1'b0;
                        o_wvalid  <= 1'b1;
                        r_beat    <= 8'd0;
                        o_wlast   <= (c_LAST_BEAT == 8'd0);
                        r_state   <= S_W;
                    end
                end
                S_W: begin
                    if (i_wready) begin
                        if (o_wlast) begin
                            o_wvalid <= 1'b0;
                            o_wlast  <= 1'b0;
                            o_bready <= 1'b1;
                            r_state  <= S_B;
                        end else begin
                            r_beat  <= r_beat + 8'd1;
                            o_wlast <= ((r_beat + 8'd1) == c_LAST_BEAT);
                        end
                    end
                end
                S_B: begin
                    if (i_bvalid) begin
                        o_bready <= 1'b0;
                        if (i_bresp != 2'b00) begin
                            o_init_error <= 1'b1;
                            r_state      <= S_ERR;
                        end else if (w_last_burst) begin
                            o_init_done <= 1'b1;
                            r_state     <= S_DONE;
                        end else begin
                            o_awaddr  <= w_next_addr[31:0];
                            o_awvalid <= 1'b1;
                            r_state   <= S_AW;
                        end
                    end
                end
                S_DONE, S_ERR: begin
                    if (i_start) begin
                        o_init_done  <= 1'b0;
                        o_init_error <= 1'b0;
                        o_awaddr     <= BASE_ADDR;
                        o_awvalid    <= 1'b1;
                        r_state      <= S_AW;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axi_ram_init_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_axi_ram_init_ctrl
// Brief   : Randomised-stall AXI slave model and reference memory for
//           axi_ram_init_ctrl; a second instance covers manual start.
// Revision: 1.0
// ============================================================================
module tb_axi_ram_init_ctrl;

    localparam logic [31:0] c_BASE1 = 32'h0;
    localparam logic [31:0] c_MEM1  = 32'h400;
    localparam int          c_BL1   = 4;
    localparam logic [63:0] c_FILL1 = 64'hA5A5_5A5A_1234_5678;
    localparam int          c_NB1   = 32;
    localparam int          c_NW1   = 128;

    localparam logic [31:0] c_BASE2 = 32'h1000;
    localparam logic [31:0] c_MEM2  = 32'h40;
    localparam int          c_BL2   = 2;
    localparam logic [63:0] c_FILL2 = 64'h0123_4567_89AB_CDEF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, i_start, awready, wready, bvalid;
    logic [1:0]  bresp;
    logic [5:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen, wstrb;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid, wlast, wvalid, bready, done, err;
    logic [63:0] wdata;

    logic        rst2, start2;
    logic [5:0]  awid2;
    logic [31:0] awaddr2;
    logic [7:0]  awlen2, wstrb2;
    logic [2:0]  awsize2;
    logic [1:0]  awburst2;
    logic        awvalid2, wlast2, wvalid2, bready2, done2, err2;
    logic [63:0] wdata2;

    axi_ram_init_ctrl #(.ID_WIDTH(6), .MEM_SIZE(c_MEM1), .BASE_ADDR(c_BASE1),
        .BURST_LEN(c_BL1), .FILL_DATA(c_FILL1), .AUTO_START(1'b1)) u_dut (
        .clk(clk), .rst(rst), .i_start(i_start),
        .o_awid(awid), .o_awaddr(awaddr), .o_awlen(awlen), .o_awsize(awsize),
        .o_awburst(awburst), .o_awvalid(awvalid), .i_awready(awready),
        .o_wdata(wdata), .o_wstrb(wstrb), .o_wlast(wlast), .o_wvalid(wvalid),
        .i_wready(wready), .i_bid(6'd0), .i_bresp(bresp), .i_bvalid(bvalid),
        .o_bready(bready), .o_init_done(done), .o_init_error(err));

    axi_ram_init_ctrl #(.ID_WIDTH(6), .MEM_SIZE(c_MEM2), .BASE_ADDR(c_BASE2),
        .BURST_LEN(c_BL2), .FILL_DATA(c_FILL2), .AUTO_START(1'b0)) u_dut_manual (
        .clk(clk), .rst(rst2), .i_start(start2),
        .o_awid(awid2), .o_awaddr(awaddr2), .o_awlen(awlen2), .o_awsize(awsize2),
        .o_awburst(awburst2), .o_awvalid(awvalid2), .i_awready(1'b1),
        .o_wdata(wdata2), .o_wstrb(wstrb2), .o_wlast(wlast2), .o_wvalid(wvalid2),
        .i_wready(1'b1), .i_bid(6'd0), .i_bresp(2'b00), .i_bvalid(1'b1),
        .o_bready(bready2), .o_init_done(done2), .o_init_error(err2));

    int n_checks = 0;
    int n_errs   = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [63:0] exp_word(input logic [31:0] a, input logic [63:0] fill);
        logic [63:0] w;
        w = fill;
`ifdef RAM_INIT_PATTERN_EN
        w = {~a, a};
`endif
        return w;
    endfunction

    // Slave model / scoreboard state
    bit          stall = 1'b0;
    int          err_burst = -1;
    logic [31:0] exp_addr, cur_addr, wa, hold_addr;
    logic [63:0] hold_wdata;
    logic        hold_wlast;
    int          aw_cnt, wb_cnt, b_cnt, beat, done_rises;
    bit          w_open, b_pending, b_fire, prev_done;
    bit          prev_aw_hold, prev_w_hold, prev_b_final, prev_b_err, prev_b_mid;
    logic [63:0] mem [0:c_NW1-1];
    bit          d2_fin = 1'b0;

    task automatic model_clear();
        exp_addr = c_BASE1; aw_cnt = 0; wb_cnt = 0; b_cnt = 0; beat = 0;
        done_rises = 0; w_open = 0; b_pending = 0;
        for (int i = 0; i < c_NW1; i++) mem[i] = 64'd0;
    endtask

    initial begin
        awready = 0; wready = 0; bvalid = 0; bresp = 0; b_fire = 0;
        prev_done = 0; prev_aw_hold = 0; prev_w_hold = 0;
        prev_b_final = 0; prev_b_err = 0; prev_b_mid = 0;
        model_clear();
        forever begin
            @(negedge clk);
            if (b_fire) begin bvalid = 0; b_fire = 0; end
            awready = stall ? ($urandom_range(0, 2) == 0) : 1'b1;
            wready  = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (b_pending && !bvalid && (!stall || $urandom_range(0, 3) == 0)) begin
                bvalid = 1;
                bresp  = (b_cnt == err_burst) ? 2'b10 : 2'b00;
            end
            #1;
            if (rst) begin
                bvalid = 0; w_open = 0; b_pending = 0; beat = 0; exp_addr = c_BASE1;
                prev_done = 0; prev_aw_hold = 0; prev_w_hold = 0;
                prev_b_final = 0; prev_b_err = 0; prev_b_mid = 0;
                continue;
            end
            if (prev_b_final) chk("done_after_last_b", done, 1);
            if (prev_b_err) begin
                chk("err_after_bad_b", err, 1);
                chk("no_done_on_err", done, 0);
            end
            if (prev_b_mid) begin
                chk("aw_one_cycle_after_b", awvalid, 1);
                chk("no_done_mid", done, 0);
            end
            prev_b_final = 0; prev_b_err = 0; prev_b_mid = 0;
            if (done && !prev_done) done_rises++;
            prev_done = done;
            if (prev_aw_hold) begin
                chk("awvalid_held", awvalid, 1);
                chk("awaddr_held", awaddr, hold_addr);
            end
            if (prev_w_hold) begin
                chk("wvalid_held", wvalid, 1);
                chk("wdata_held", wdata, hold_wdata);
                chk("wlast_held", wlast, hold_wlast);
            end
            prev_aw_hold = awvalid && !awready; hold_addr = awaddr;
            prev_w_hold  = wvalid && !wready;   hold_wdata = wdata; hold_wlast = wlast;
            if (wvalid && !w_open) chk("w_before_aw", wvalid, 0);
            if (awvalid && awready) begin
                chk("aw_addr", awaddr, exp_addr);
                chk("aw_len", awlen, c_BL1 - 1);
                chk("aw_ctl", {awid, awsize, awburst}, {6'd0, 3'd3, 2'b01});
                chk("aw_outstanding", w_open || b_pending, 0);
                aw_cnt++; w_open = 1; beat = 0; cur_addr = exp_addr;
                exp_addr = exp_addr + 32'(8 * c_BL1);
            end
            if (wvalid && wready && w_open) begin
                wa = cur_addr + 32'(8 * beat);
                chk("w_last", wlast, beat == c_BL1 - 1);
                chk("w_data", wdata, exp_word(wa, c_FILL1));
                chk("w_strb", wstrb, 8'hFF);
                mem[(wa - c_BASE1) >> 3] = wdata;
                wb_cnt++;
                if (beat == c_BL1 - 1) begin w_open = 0; b_pending = 1; end
                beat++;
            end
            if (bvalid && bready) begin
                b_fire = 1; b_pending = 0;
                if (bresp != 2'b00)                  prev_b_err = 1;
                else if (exp_addr == c_BASE1 + c_MEM1) prev_b_final = 1;
                else                                   prev_b_mid = 1;
                b_cnt++;
            end
        end
    end

    task automatic wait_end(input int maxc);
        int n = 0;
        while (!(done || err) && n < maxc) begin
            @(negedge clk);
            n++;
        end
        chk("end_timeout", n < maxc, 1);
        repeat (3) @(negedge clk);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        model_clear();
        i_start = 1;
        @(negedge clk);
        i_start = 0;
    endtask

    task automatic check_full(input string tag);
        int bad = 0;
        chk({tag, "_aw_cnt"}, aw_cnt, c_NB1);
        chk({tag, "_w_beats"}, wb_cnt, c_NW1);
        chk({tag, "_b_cnt"}, b_cnt, c_NB1);
        chk({tag, "_done_once"}, done_rises, 1);
        chk({tag, "_done"}, done, 1);
        chk({tag, "_err"}, err, 0);
        for (int i = 0; i < c_NW1; i++)
            if (mem[i] !== exp_word(c_BASE1 + 32'(8 * i), c_FILL1)) bad++;
        chk({tag, "_mem"}, bad, 0);
    endtask

    initial begin
        int n;
        rst = 1; i_start = 0;
        repeat (3) @(negedge clk);
        chk("rst_awvalid", awvalid, 0);
        chk("rst_wvalid", wvalid, 0);
        chk("rst_bready", bready, 0);
        chk("rst_awaddr", awaddr, c_BASE1);
        chk("rst_done_err", {done, err}, 2'b00);
        rst = 0;
        @(negedge clk);
        chk("autostart_aw", awvalid, 1);
        wait_end(2000);
        check_full("ready");

        stall = 1;
        pulse_start();
        repeat (40) @(negedge clk);
        i_start = 1; @(negedge clk); i_start = 0;
        wait_end(5000);
        check_full("stall");

        err_burst = 4;
        pulse_start();
        wait_end(5000);
        chk("err_flag", err, 1);
        chk("err_no_done", done, 0);
        repeat (20) @(negedge clk);
        chk("err_no_more_aw", aw_cnt, 5);
        chk("err_idle_aw", awvalid, 0);
        err_burst = -1;
        pulse_start();
        chk("err_cleared", err, 0);
        wait_end(5000);
        check_full("restart");

        pulse_start();
        n = 0;
        while (!(aw_cnt == 10 && beat == 2 && w_open) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("midw_timeout", n < 5000, 1);
        rst = 1;
        @(negedge clk);
        chk("midw_rst_valids", {awvalid, wvalid, bready}, 3'b000);
        chk("midw_rst_flags", {done, err}, 2'b00);
        chk("midw_rst_addr", awaddr, c_BASE1);
        model_clear();
        rst = 0;
        wait_end(5000);
        check_full("after_rst");

        n = 0;
        while (!d2_fin && n < 2000) begin @(negedge clk); n++; end
        chk("manual_timeout", d2_fin, 1);
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

    // Manual-start instance with an always-ready slave
    initial begin
        logic [63:0] mem2 [0:7];
        logic [31:0] c2;
        int b2, n2, bad2;
        bit seen;
        rst2 = 1; start2 = 0; seen = 0; b2 = 0; c2 = c_BASE2;
        for (int i = 0; i < 8; i++) mem2[i] = 64'd0;
        repeat (2) @(negedge clk);
        rst2 = 0;
        repeat (100) begin
            @(negedge clk);
            if (awvalid2 || wvalid2) seen = 1;
        end
        chk("manual_no_aw", seen, 0);
        start2 = 1;
        @(negedge clk);
        start2 = 0;
        chk("manual_aw", awvalid2, 1);
        chk("manual_aw_addr", awaddr2, c_BASE2);
        n2 = 0;
        while (!done2 && n2 < 300) begin
            if (awvalid2) begin c2 = awaddr2; b2 = 0; end
            if (wvalid2) begin
                mem2[((c2 + 32'(8 * b2)) - c_BASE2) >> 3] = wdata2;
                b2++;
            end
            @(negedge clk);
            n2++;
        end
        chk("manual_done", done2, 1);
        bad2 = 0;
        for (int i = 0; i < 8; i++)
            if (mem2[i] !== exp_word(c_BASE2 + 32'(8 * i), c_FILL2)) bad2++;
        chk("manual_mem", bad2, 0);
`ifdef RAM_INIT_PATTERN_EN
        chk("pattern_1008", mem2[1], 64'hFFFF_EFF7_0000_1008);
`else
        chk("fill_1008", mem2[1], c_FILL2);
`endif
        d2_fin = 1;
    end

endmodule
`default_nettype wire
